// File: rtl/bigsub_pkg.sv
// Shared types and sizing helpers for the digit-serial three-operand subtractor.
package bigsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Per-chunk borrow spans 0..2, so two bits are needed.
  typedef logic [1:0] borrow_t;

  function automatic int unsigned calc_k(input int unsigned n, input int unsigned w);
    return n / w;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned k);
    return (k <= 1) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/bigsub3_chunk.sv
// One W-bit slice of a - b - c - brw, producing the result chunk and the borrow (0..2).
module bigsub3_chunk
  import bigsub_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_k,
  input  logic [W-1:0] b_k,
  input  logic [W-1:0] c_k,
  input  borrow_t      brw_in,
  output logic [W-1:0] d_k,
  output borrow_t      brw_out
);

  logic [W+1:0] d;

  // Top two bits of the W+2-bit difference are floor(d / 2^W); its negation is the borrow.
  always_comb begin
    d       = {2'b00, a_k} - {2'b00, b_k} - {2'b00, c_k} - {W'(0), brw_in};
    d_k     = d[W-1:0];
    brw_out = 2'b00 - d[W+1:W];
  end

endmodule

// File: rtl/bigsub3_serial.sv
// Digit-serial (a - b - c - borrow_in) mod 2^N, one W-bit chunk per cycle, LSB chunk first.
module bigsub3_serial
  import bigsub_pkg::*;
#(
  parameter int unsigned N = 1024,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic [N-1:0] c_in,
  input  logic         borrow_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff_out,
  output borrow_t      borrow_out
);

  localparam int unsigned K  = calc_k(N, W);
  localparam int unsigned CW = calc_cnt_w(K);

  if (W < 2 || (N % W) != 0) begin : g_bad_params
    $error("bigsub3_serial: W must be at least 2 and must divide N");
  end

  state_t          state;
  logic [N-1:0]    a_sr;
  logic [N-1:0]    b_sr;
  logic [N-1:0]    c_sr;
  borrow_t         brw;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    d_k;
  borrow_t         brw_next;
  logic [N-1:0]    diff_next;

  bigsub3_chunk #(.W(W)) u_chunk (
    .a_k     (a_sr[W-1:0]),
    .b_k     (b_sr[W-1:0]),
    .c_k     (c_sr[W-1:0]),
    .brw_in  (brw),
    .d_k     (d_k),
    .brw_out (brw_next)
  );

  // The result register fills from the top; after K chunks the LSB chunk sits at bit 0.
  if (K > 1) begin : g_multi
    assign diff_next = {d_k, diff_out[N-1:W]};
  end else begin : g_single
    assign diff_next = d_k;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff_out   <= '0;
      borrow_out <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      c_sr       <= '0;
      brw        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            c_sr     <= c_in;
            brw      <= {1'b0, borrow_in};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> W;
          b_sr     <= b_sr >> W;
          c_sr     <= c_sr >> W;
          brw      <= brw_next;
          diff_out <= diff_next;
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(K - 1)) begin
            borrow_out <= brw_next;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it; busy inputs are not captured.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bigsub3_serial.sv
// Bench for bigsub3_serial: a K=4 instance (N=32, W=8) and a K=1 instance (N=32, W=32).
module tb_bigsub3_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_in, b_in, c_in;
  logic        borrow_in;

  logic        iv8, iv32, or8, or32;
  logic        rdy8, rdy32, ov8, ov32;
  logic [31:0] diff8, diff32;
  logic [1:0]  bo8, bo32;

  logic        in_ready_m, out_valid_m;
  logic [31:0] diff_m;
  logic [1:0]  borrow_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign iv8  = in_valid & ~sel;
  assign iv32 = in_valid & sel;
  assign or8  = out_ready & ~sel;
  assign or32 = out_ready & sel;
  assign in_ready_m  = sel ? rdy32 : rdy8;
  assign out_valid_m = sel ? ov32 : ov8;
  assign diff_m      = sel ? diff32 : diff8;
  assign borrow_m    = sel ? bo32 : bo8;

  bigsub3_serial #(.N(32), .W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(rdy8),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .borrow_in(borrow_in),
    .out_valid(ov8), .out_ready(or8), .diff_out(diff8), .borrow_out(bo8)
  );

  bigsub3_serial #(.N(32), .W(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(rdy32),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .borrow_in(borrow_in),
    .out_valid(ov32), .out_ready(or32), .diff_out(diff32), .borrow_out(bo32)
  );

  // Reference: exact integer difference, then split into mod-2^32 value and wrap count.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input logic bi, output logic [31:0] d, output logic [1:0] br);
    longint t;
    longint two32;
    two32 = longint'(1) << 32;
    t = longint'(a) - longint'(b) - longint'(c) - longint'(bi);
    d = 32'(t);
    if (t >= 0)           br = 2'd0;
    else if (t >= -two32) br = 2'd1;
    else                  br = 2'd2;
  endfunction

  function automatic logic [31:0] rnd_operand();
    int unsigned pick;
    pick = $urandom_range(0, 3);
    if (pick == 0) return 32'h0;
    if (pick == 1) return 32'hFFFF_FFFF;
    return 32'($urandom);
  endfunction

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic bi);
    int n;
    n = 0;
    @(negedge clk);
    sel = s; a_in = a; b_in = b; c_in = c; borrow_in = bi; in_valid = 1'b1;
    while (!in_ready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge to out_valid; -1 when the bound expires.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid_m && lat < 50);
    if (!out_valid_m) lat = -1;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({rdy8, ov8, diff8, bo8} !== {1'b1, 1'b0, 32'h0, 2'b0}) begin
      errors++;
      $display("FAIL reset_k4: rdy=%b ov=%b diff=%h br=%0d want rdy=1 ov=0 diff=0 br=0", rdy8, ov8, diff8, bo8);
    end
    checks++;
    if ({rdy32, ov32, diff32, bo32} !== {1'b1, 1'b0, 32'h0, 2'b0}) begin
      errors++;
      $display("FAIL reset_k1: rdy=%b ov=%b diff=%h br=%0d want rdy=1 ov=0 diff=0 br=0", rdy32, ov32, diff32, bo32);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [3] = '{32'd5, 32'd0, 32'd0};
    logic [31:0] vb [3] = '{32'd3, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] vc [3] = '{32'd1, 32'd0, 32'hFFFF_FFFF};
    logic        vi [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] ed;
    logic [1:0]  eb;
    int lat;
    for (int i = 0; i < 3; i++) begin
      model(va[i], vb[i], vc[i], vi[i], ed, eb);
      start_op(1'b0, va[i], vb[i], vc[i], vi[i]);
      wait_out(lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat); end
      checks++;
      if (diff_m !== ed || borrow_m !== eb) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h/%0d want %h/%0d", i, diff_m, borrow_m, ed, eb);
      end
      finish_out();
      checks++;
      if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
        errors++;
        $display("FAIL directed_release[%0d]: ov=%b rdy=%b want ov=0 rdy=1", i, out_valid_m, in_ready_m);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c, ed, ed2;
    logic [1:0]  eb, eb2;
    logic        bi;
    int lat;
    a = rnd_operand(); b = rnd_operand(); c = rnd_operand(); bi = 1'($urandom);
    model(a, b, c, bi, ed, eb);
    start_op(1'b0, a, b, c, bi);
    wait_out(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL stall_latency: got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 3 == 1) begin
        in_valid = 1'b1; a_in = ~a; b_in = a; c_in = 32'h1234_5678; borrow_in = ~bi;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || diff_m !== ed || borrow_m !== eb) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ov=%b rdy=%b diff=%h br=%0d want ov=1 rdy=0 diff=%h br=%0d",
                 i, out_valid_m, in_ready_m, diff_m, borrow_m, ed, eb);
      end
    end
    in_valid = 1'b0;
    finish_out();
    checks++;
    if (in_ready_m !== 1'b1 || diff_m !== ed || borrow_m !== eb) begin
      errors++;
      $display("FAIL stall_release: rdy=%b diff=%h br=%0d want rdy=1 diff=%h br=%0d", in_ready_m, diff_m, borrow_m, ed, eb);
    end
    a = rnd_operand(); b = rnd_operand(); c = rnd_operand();
    model(a, b, c, 1'b0, ed2, eb2);
    start_op(1'b0, a, b, c, 1'b0);
    wait_out(lat);
    checks++;
    if (lat !== 4 || diff_m !== ed2 || borrow_m !== eb2) begin
      errors++;
      $display("FAIL stall_next_op: lat=%0d diff=%h br=%0d want lat=4 diff=%h br=%0d", lat, diff_m, borrow_m, ed2, eb2);
    end
    finish_out();
  endtask

  task automatic test_reset_midop();
    int lat;
    start_op(1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy8 !== 1'b0) begin errors++; $display("FAIL midop_busy: rdy=%b want 0", rdy8); end
    reset = 1'b1;
    #1;
    checks++;
    if (ov8 !== 1'b0 || rdy8 !== 1'b1 || diff8 !== 32'h0 || bo8 !== 2'b0) begin
      errors++;
      $display("FAIL midop_abort: ov=%b rdy=%b diff=%h br=%0d want ov=0 rdy=1 diff=0 br=0", ov8, rdy8, diff8, bo8);
    end
    @(negedge clk);
    reset = 1'b0;
    start_op(1'b0, 32'h100, 32'h1, 32'h0, 1'b0);
    wait_out(lat);
    checks++;
    if (lat !== 4 || diff_m !== 32'h0000_00FF || borrow_m !== 2'd0) begin
      errors++;
      $display("FAIL midop_recover: lat=%0d diff=%h br=%0d want lat=4 diff=000000ff br=0", lat, diff_m, borrow_m);
    end
    finish_out();
  endtask

  task automatic test_k1();
    int lat;
    start_op(1'b1, 32'h10, 32'h8, 32'h8, 1'b1);
    wait_out(lat);
    checks++;
    if (lat !== 1 || diff_m !== 32'hFFFF_FFFF || borrow_m !== 2'd1) begin
      errors++;
      $display("FAIL k1_directed: lat=%0d diff=%h br=%0d want lat=1 diff=ffffffff br=1", lat, diff_m, borrow_m);
    end
    finish_out();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c, ed;
    logic [1:0]  eb;
    logic        bi;
    int lat, want_lat;
    for (int s = 0; s < 2; s++) begin
      want_lat = (s == 0) ? 4 : 1;
      for (int i = 0; i < 25; i++) begin
        a = rnd_operand(); b = rnd_operand(); c = rnd_operand(); bi = 1'($urandom);
        model(a, b, c, bi, ed, eb);
        start_op(1'(s), a, b, c, bi);
        wait_out(lat);
        checks++;
        if (lat !== want_lat || diff_m !== ed || borrow_m !== eb) begin
          errors++;
          $display("FAIL b2b[s%0d][%0d] %h-%h-%h-%b: lat=%0d diff=%h br=%0d want lat=%0d diff=%h br=%0d",
                   s, i, a, b, c, bi, lat, diff_m, borrow_m, want_lat, ed, eb);
        end
        finish_out();
      end
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_k1();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
